// File: rtl/riscv_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner
// encodings and the byte-enable width helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        RISCV_ARB_IDLE    = 2'd0,
        RISCV_ARB_REQ     = 2'd1,
        RISCV_ARB_WAIT_RD = 2'd2
    } arb_state_t;

    typedef enum logic {
        RISCV_ARB_OWN_FETCH = 1'b0,
        RISCV_ARB_OWN_DATA  = 1'b1
    } arb_owner_t;

    function automatic int unsigned riscv_be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Core fetch/data ports plus the shared memory port of the arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface riscv_mem_arbiter_if #(
    parameter int unsigned MP_DATA_WIDTH = 32,
    parameter int unsigned MP_ADDR_WIDTH = 32
);
    localparam int unsigned BW = riscv_pkg::riscv_be_width(MP_DATA_WIDTH);

    logic                     ifetch_req;
    logic [MP_ADDR_WIDTH-1:0] ifetch_addr;
    logic                     ofetch_gnt;
    logic                     ofetch_rvalid;
    logic [MP_DATA_WIDTH-1:0] ofetch_rdata;

    logic                     idata_req;
    logic                     idata_we;
    logic [BW-1:0]            idata_be;
    logic [MP_ADDR_WIDTH-1:0] idata_addr;
    logic [MP_DATA_WIDTH-1:0] idata_wdata;
    logic                     odata_gnt;
    logic                     odata_rvalid;
    logic [MP_DATA_WIDTH-1:0] odata_rdata;

    logic                     oerr;

    logic                     omem_req;
    logic                     omem_we;
    logic [BW-1:0]            omem_be;
    logic [MP_ADDR_WIDTH-1:0] omem_addr;
    logic [MP_DATA_WIDTH-1:0] omem_wdata;
    logic                     imem_gnt;
    logic                     imem_rvalid;
    logic [MP_DATA_WIDTH-1:0] imem_rdata;

    modport slave (
        input  ifetch_req, ifetch_addr,
        output ofetch_gnt, ofetch_rvalid, ofetch_rdata,
        input  idata_req, idata_we, idata_be, idata_addr, idata_wdata,
        output odata_gnt, odata_rvalid, odata_rdata,
        output oerr,
        output omem_req, omem_we, omem_be, omem_addr, omem_wdata,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport master (
        output ifetch_req, ifetch_addr,
        input  ofetch_gnt, ofetch_rvalid, ofetch_rdata,
        output idata_req, idata_we, idata_be, idata_addr, idata_wdata,
        input  odata_gnt, odata_rvalid, odata_rdata,
        input  oerr,
        input  omem_req, omem_we, omem_be, omem_addr, omem_wdata,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/riscv_arb_select.sv
// Winner selection between fetch and data requesters, with a consecutive
// data-grant counter that hands the next slot to a waiting fetch.
module riscv_arb_select
    import riscv_pkg::*;
#(
    parameter int unsigned MP_DATA_MAX_CONSEC = 4
) (
    input  logic       iclk,
    input  logic       irstn,
    input  logic       ifetch_req,
    input  logic       idata_req,
    input  logic       itake,
    output arb_owner_t oowner
);
    localparam int unsigned CW = (MP_DATA_MAX_CONSEC < 1) ? 1 : $clog2(MP_DATA_MAX_CONSEC + 1);
    localparam logic [CW-1:0] CMAX = CW'(MP_DATA_MAX_CONSEC);

    logic [CW-1:0] consec_q;

    always_comb begin
        oowner = RISCV_ARB_OWN_DATA;
        if (ifetch_req && (!idata_req || consec_q == CMAX))
            oowner = RISCV_ARB_OWN_FETCH;
    end

    // Any cycle without a waiting fetch resets the fairness window.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            consec_q <= '0;
        end else if (!ifetch_req) begin
            consec_q <= '0;
        end else if (itake) begin
            if (oowner == RISCV_ARB_OWN_FETCH)
                consec_q <= '0;
            else if (consec_q != CMAX)
                consec_q <= consec_q + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between core fetch and data ports: one
// outstanding transaction, data priority with fetch fairness, and a timeout abort.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned MP_DATA_WIDTH      = 32,
    parameter int unsigned MP_ADDR_WIDTH      = 32,
    parameter int unsigned MP_DATA_MAX_CONSEC = 4,
    parameter int unsigned MP_TIMEOUT         = 255
) (
    input logic                iclk,
    input logic                irstn,
    riscv_mem_arbiter_if.slave bus
);
    localparam int unsigned BW   = riscv_be_width(MP_DATA_WIDTH);
    localparam logic [7:0]  TMAX = 8'(MP_TIMEOUT);

    arb_state_t               state_q, state_d;
    arb_owner_t               owner_q, sel_owner;
    logic                     mem_we_q;
    logic [BW-1:0]            mem_be_q;
    logic [MP_ADDR_WIDTH-1:0] mem_addr_q;
    logic [MP_DATA_WIDTH-1:0] mem_wdata_q;
    logic [7:0]               tmo_q;

    logic                     any_req, take, timeout;
    logic                     mem_req, gnt, rvalid, err;
    logic [MP_DATA_WIDTH-1:0] rdata;

    assign any_req = bus.ifetch_req | bus.idata_req;
    assign take    = (state_q == RISCV_ARB_IDLE) && any_req;
    assign timeout = (tmo_q == TMAX);

    riscv_arb_select #(
        .MP_DATA_MAX_CONSEC(MP_DATA_MAX_CONSEC)
    ) u_select (
        .iclk       (iclk),
        .irstn      (irstn),
        .ifetch_req (bus.ifetch_req),
        .idata_req  (bus.idata_req),
        .itake      (take),
        .oowner     (sel_owner)
    );

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        unique case (state_q)
            RISCV_ARB_IDLE: begin
                if (any_req)
                    state_d = RISCV_ARB_REQ;
            end
            RISCV_ARB_REQ: begin
                // Abort wins over a same-cycle memory grant: the request is already withdrawn.
                if (timeout) begin
                    gnt     = 1'b1;
                    rvalid  = !mem_we_q;
                    err     = 1'b1;
                    state_d = RISCV_ARB_IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (bus.imem_gnt) begin
                        gnt     = 1'b1;
                        state_d = mem_we_q ? RISCV_ARB_IDLE : RISCV_ARB_WAIT_RD;
                    end
                end
            end
            RISCV_ARB_WAIT_RD: begin
                if (bus.imem_rvalid) begin
                    rvalid  = 1'b1;
                    rdata   = bus.imem_rdata;
                    state_d = RISCV_ARB_IDLE;
                end else if (timeout) begin
                    rvalid  = 1'b1;
                    err     = 1'b1;
                    state_d = RISCV_ARB_IDLE;
                end
            end
            default: state_d = RISCV_ARB_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state_q     <= RISCV_ARB_IDLE;
            owner_q     <= RISCV_ARB_OWN_FETCH;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                tmo_q <= '0;
            else if (state_q != RISCV_ARB_IDLE && tmo_q != 8'hFF)
                tmo_q <= tmo_q + 8'd1;
            if (take) begin
                owner_q <= sel_owner;
                if (sel_owner == RISCV_ARB_OWN_FETCH) begin
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= '1;
                    mem_addr_q  <= bus.ifetch_addr;
                    mem_wdata_q <= '0;
                end else begin
                    mem_we_q    <= bus.idata_we;
                    mem_be_q    <= bus.idata_we ? bus.idata_be : '1;
                    mem_addr_q  <= bus.idata_addr;
                    mem_wdata_q <= bus.idata_wdata;
                end
            end
        end
    end

    assign bus.ofetch_gnt    = gnt    && (owner_q == RISCV_ARB_OWN_FETCH);
    assign bus.ofetch_rvalid = rvalid && (owner_q == RISCV_ARB_OWN_FETCH);
    assign bus.ofetch_rdata  = (owner_q == RISCV_ARB_OWN_FETCH) ? rdata : '0;
    assign bus.odata_gnt     = gnt    && (owner_q == RISCV_ARB_OWN_DATA);
    assign bus.odata_rvalid  = rvalid && (owner_q == RISCV_ARB_OWN_DATA);
    assign bus.odata_rdata   = (owner_q == RISCV_ARB_OWN_DATA) ? rdata : '0;
    assign bus.oerr          = err;
    assign bus.omem_req      = mem_req;
    assign bus.omem_we       = mem_we_q;
    assign bus.omem_be       = mem_be_q;
    assign bus.omem_addr     = mem_addr_q;
    assign bus.omem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: per-cycle vector table plus
// hand-written sequences for fairness, timeout and mid-transaction reset.
module tb_riscv_mem_arbiter;
    import riscv_pkg::*;

    localparam logic       Y  = 1'b1;
    localparam logic       N  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [3:0]  BF = 4'hF;
    localparam logic [3:0]  B0 = 4'h0;

    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        mgnt;
        logic        mrv;
        logic [31:0] mrdata;
        logic        efgnt;
        logic        efrv;
        logic [31:0] efrd;
        logic        edgnt;
        logic        edrv;
        logic [31:0] edrd;
        logic        eerr;
        logic        emreq;
        logic        emwe;
        logic [3:0]  embe;
        logic [31:0] emaddr;
        logic [31:0] emwdata;
    } vec_t;

    logic iclk  = 1'b0;
    logic irstn = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t vecs [14];

    riscv_mem_arbiter_if #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) bus ();

    riscv_mem_arbiter #(
        .MP_DATA_WIDTH      (32),
        .MP_ADDR_WIDTH      (32),
        .MP_DATA_MAX_CONSEC (4),
        .MP_TIMEOUT         (255)
    ) dut (
        .iclk  (iclk),
        .irstn (irstn),
        .bus   (bus)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.ifetch_req  = v.freq;
        bus.ifetch_addr = v.faddr;
        bus.idata_req   = v.dreq;
        bus.idata_we    = v.dwe;
        bus.idata_be    = v.dbe;
        bus.idata_addr  = v.daddr;
        bus.idata_wdata = v.dwdata;
        bus.imem_gnt    = v.mgnt;
        bus.imem_rvalid = v.mrv;
        bus.imem_rdata  = v.mrdata;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".fetch_gnt"},    32'(bus.ofetch_gnt),    32'(v.efgnt));
        check({tag, ".fetch_rvalid"}, 32'(bus.ofetch_rvalid), 32'(v.efrv));
        check({tag, ".fetch_rdata"},  bus.ofetch_rdata,       v.efrd);
        check({tag, ".data_gnt"},     32'(bus.odata_gnt),     32'(v.edgnt));
        check({tag, ".data_rvalid"},  32'(bus.odata_rvalid),  32'(v.edrv));
        check({tag, ".data_rdata"},   bus.odata_rdata,        v.edrd);
        check({tag, ".err"},          32'(bus.oerr),          32'(v.eerr));
        check({tag, ".mem_req"},      32'(bus.omem_req),      32'(v.emreq));
        check({tag, ".mem_we"},       32'(bus.omem_we),       32'(v.emwe));
        check({tag, ".mem_be"},       32'(bus.omem_be),       32'(v.embe));
        check({tag, ".mem_addr"},     bus.omem_addr,          v.emaddr);
        check({tag, ".mem_wdata"},    bus.omem_wdata,         v.emwdata);
    endtask

    vec_t zero_v;

    initial begin
        int unsigned n_gnt;
        int unsigned n_cyc;
        logic        seen;
        logic [9:0]  exp_order;

        zero_v = '{N,Z,N,N,B0,Z,Z, N,N,Z, N,N,Z, N,N,Z, N, N,N,B0,Z,Z};

        // Fetch read, store, then a simultaneous load/fetch pair with stray memory strobes.
        vecs[0]  = '{Y,32'h100,N,N,B0,Z,Z,                 N,N,Z,            N,N,Z,            N,N,Z,            N, N,N,B0,Z,Z};
        vecs[1]  = '{Y,32'h100,N,N,B0,Z,Z,                 Y,N,Z,            Y,N,Z,            N,N,Z,            N, Y,N,BF,32'h100,Z};
        vecs[2]  = '{N,Z,N,N,B0,Z,Z,                       N,Y,32'hCAFEF00D, N,Y,32'hCAFEF00D, N,N,Z,            N, N,N,BF,32'h100,Z};
        vecs[3]  = '{N,Z,N,N,B0,Z,Z,                       N,N,Z,            N,N,Z,            N,N,Z,            N, N,N,BF,32'h100,Z};
        vecs[4]  = '{N,Z,Y,Y,4'h3,32'h20,32'h1234,         N,N,Z,            N,N,Z,            N,N,Z,            N, N,N,BF,32'h100,Z};
        vecs[5]  = '{N,Z,Y,Y,4'h3,32'h20,32'h1234,         Y,N,Z,            N,N,Z,            Y,N,Z,            N, Y,Y,4'h3,32'h20,32'h1234};
        vecs[6]  = '{N,Z,N,N,B0,Z,Z,                       N,Y,32'h77,       N,N,Z,            N,N,Z,            N, N,Y,4'h3,32'h20,32'h1234};
        vecs[7]  = '{Y,32'h200,Y,N,B0,32'h40,Z,            N,N,Z,            N,N,Z,            N,N,Z,            N, N,Y,4'h3,32'h20,32'h1234};
        vecs[8]  = '{Y,32'h200,Y,N,B0,32'h40,Z,            Y,Y,32'h55,       N,N,Z,            Y,N,Z,            N, Y,N,BF,32'h40,Z};
        vecs[9]  = '{Y,32'h200,N,N,B0,Z,Z,                 N,Y,32'hDEADBEEF, N,N,Z,            N,Y,32'hDEADBEEF, N, N,N,BF,32'h40,Z};
        vecs[10] = '{Y,32'h200,N,N,B0,Z,Z,                 Y,N,Z,            N,N,Z,            N,N,Z,            N, N,N,BF,32'h40,Z};
        vecs[11] = '{Y,32'h200,N,N,B0,Z,Z,                 Y,N,Z,            Y,N,Z,            N,N,Z,            N, Y,N,BF,32'h200,Z};
        vecs[12] = '{N,Z,N,N,B0,Z,Z,                       N,Y,32'h11112222, N,Y,32'h11112222, N,N,Z,            N, N,N,BF,32'h200,Z};
        vecs[13] = '{N,Z,N,N,B0,Z,Z,                       N,N,Z,            N,N,Z,            N,N,Z,            N, N,N,BF,32'h200,Z};

        apply(zero_v);
        #12;
        check_outputs("reset", zero_v);

        @(negedge iclk);
        irstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge iclk);
            apply(vecs[i]);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i]);
        end

        // Fairness: both requesters held, memory always ready.
        exp_order = 10'b0111101111;
        n_gnt = 0;
        for (int c = 0; c < 100 && n_gnt < 10; c++) begin
            @(negedge iclk);
            apply('{Y,32'h400,Y,N,B0,32'h800,Z, Y,Y,32'h1, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
            #1;
            if (bus.ofetch_gnt || bus.odata_gnt) begin
                check($sformatf("order%0d", n_gnt), 32'(bus.odata_gnt), 32'(exp_order[n_gnt]));
                n_gnt++;
            end
        end
        check("order.count", n_gnt, 32'd10);
        for (int c = 0; c < 3; c++) begin
            @(negedge iclk);
            apply('{N,Z,N,N,B0,Z,Z, N,Y,32'h1, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        end
        @(negedge iclk);
        apply(zero_v);

        // Load whose data never returns: abort after the timeout window.
        @(negedge iclk);
        apply('{N,Z,Y,N,B0,32'h80,Z, Y,N,32'hFFFFFFFF, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        @(negedge iclk);
        #1;
        check("tmo.data_gnt", 32'(bus.odata_gnt), 32'd1);
        n_cyc = 0;
        seen  = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge iclk);
            apply('{N,Z,N,N,B0,Z,Z, N,N,32'hFFFFFFFF, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
            #1;
            if (bus.oerr) seen = 1'b1;
            else n_cyc++;
        end
        check("tmo.seen", 32'(seen), 32'd1);
        check("tmo.wait_cycles", n_cyc, 32'd255);
        check("tmo.data_rvalid", 32'(bus.odata_rvalid), 32'd1);
        check("tmo.data_rdata", bus.odata_rdata, 32'h0);
        check("tmo.fetch_rvalid", 32'(bus.ofetch_rvalid), 32'd0);
        @(negedge iclk);
        #1;
        check("tmo.err_cleared", 32'(bus.oerr), 32'd0);
        check("tmo.rvalid_cleared", 32'(bus.odata_rvalid), 32'd0);

        // Reset asserted mid-read, then a stray rvalid, then a fresh fetch.
        @(negedge iclk);
        apply('{Y,32'h180,N,N,B0,Z,Z, Y,N,Z, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        @(negedge iclk);
        #1;
        check("rst.fetch_gnt", 32'(bus.ofetch_gnt), 32'd1);
        check("rst.mem_addr", bus.omem_addr, 32'h180);
        @(negedge iclk);
        apply(zero_v);
        #1;
        check("rst.pre_mem_be", 32'(bus.omem_be), 32'hF);
        irstn = 1'b0;
        #1;
        check_outputs("rst.async", zero_v);
        @(negedge iclk);
        irstn = 1'b1;
        apply('{N,Z,N,N,B0,Z,Z, N,Y,32'h99, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        #1;
        check("rst.stray_rvalid", 32'(bus.ofetch_rvalid), 32'd0);
        check("rst.stray_rdata", bus.ofetch_rdata, 32'h0);
        @(negedge iclk);
        apply('{Y,32'h300,N,N,B0,Z,Z, N,N,Z, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        #1;
        check("rst.idle_mem_req", 32'(bus.omem_req), 32'd0);
        @(negedge iclk);
        apply('{Y,32'h300,N,N,B0,Z,Z, Y,N,Z, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        #1;
        check("rst.next_mem_req", 32'(bus.omem_req), 32'd1);
        check("rst.next_mem_addr", bus.omem_addr, 32'h300);
        check("rst.next_fetch_gnt", 32'(bus.ofetch_gnt), 32'd1);
        @(negedge iclk);
        apply('{N,Z,N,N,B0,Z,Z, N,Y,32'hA5A5A5A5, N,N,Z, N,N,Z, N, N,N,B0,Z,Z});
        #1;
        check("rst.next_fetch_rvalid", 32'(bus.ofetch_rvalid), 32'd1);
        check("rst.next_fetch_rdata", bus.ofetch_rdata, 32'hA5A5A5A5);
        @(negedge iclk);
        apply(zero_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
